// File: rtl/histo_readout_pkg.sv
// Shared types and constants for the histogram readout block.
package histo_readout_pkg;

    localparam int NUM_BINS   = 1024;
    localparam int BIN_W      = 10;
    localparam int CNT_W      = 24;
    localparam int RD_LAT     = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int OUT_W      = 32;
    localparam int PKT_WORDS  = NUM_BINS + 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] HDR_TAG   = 8'h48;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_WAIT,
        ST_FTR,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic             last;
        logic [OUT_W-1:0] data;
    } fifo_word_t;

    function automatic logic [OUT_W-1:0] hdr_word(input logic [15:0] fid);
        return {SYNC_BYTE, HDR_TAG, fid};
    endfunction

endpackage

// File: rtl/histo_readout_if.sv
// Valid/ready stream carrying the framed histogram packet to the host link.
interface histo_readout_if;
    import histo_readout_pkg::*;

    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/histo_readout_fifo.sv
// Small synchronous output buffer for {last,data} words; exposes its fill count
// so the reader can budget outstanding histogram reads against free space.
module histo_out_fifo
    import histo_readout_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  fifo_word_t            wr_word,
    input  logic                  rd_en,
    output fifo_word_t            rd_word,
    output logic                  empty,
    output logic                  full,
    output logic [FIFO_CNT_W-1:0] count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    fifo_word_t       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_word = mem[rd_ptr];

    // Storage array; contents need no reset because reads are gated by count.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + FIFO_CNT_W'(wr_ok) - FIFO_CNT_W'(rd_ok);
        end
    end

endmodule

// File: rtl/histo_readout.sv
// Histogram readout: walks every bin once through the clear-on-read port and
// streams header, one word per bin, and a checksum footer.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  IDLE    | histogram owns the RAM (hist_rw=1), waiting for start
//  HDR     | push header word {SYNC_BYTE, 8'h48, frame_id}
//  RD      | issue one bin read per clock while FIFO credit allows
//  WAIT    | all bins issued, draining in-flight read data
//  FTR     | push checksum footer with last flag
//  DONE    | wait for footer handshake, then hand RAM back
module histo_readout
    import histo_readout_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      frame_id,
    output logic             hist_rw,
    output logic [BIN_W-1:0] bin_addr,
    output logic             bin_rd,
    input  logic [CNT_W-1:0] bin_data,
    histo_readout_if.master  out_if,
    output logic             busy,
    output logic             start_err
);

    state_t                state_q;
    state_t                state_d;
    logic [15:0]           frame_q;
    logic [OUT_W-1:0]      sum_q;
    logic [BIN_W-1:0]      rd_idx_q;
    logic [BIN_W-1:0]      bin_addr_q;
    logic                  bin_rd_q;
    logic [RD_LAT-1:0]     vld_sr_q;
    logic                  start_err_q;

    logic                  push;
    fifo_word_t            push_word;
    logic                  issue;
    logic                  pop;
    fifo_word_t            head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [7:0]            inflight;
    logic                  credit_ok;
    logic                  data_valid;
    logic                  last_bin;
    logic                  footer_hs;

    histo_out_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_word (push_word),
        .rd_en   (pop),
        .rd_word (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = fifo_empty ? '0 : head.data;
    assign out_if.out_last  = !fifo_empty && head.last;
    assign pop              = !fifo_empty && out_if.out_ready;
    assign footer_hs        = out_if.out_valid && out_if.out_ready && out_if.out_last;

    assign data_valid = vld_sr_q[RD_LAT-1];
    assign last_bin   = (rd_idx_q == BIN_W'(NUM_BINS - 1));
    // Outstanding reads plus buffered words may never exceed the FIFO, so
    // returning data always has a slot and no bin is ever re-read.
    assign credit_ok  = (8'(fifo_count) + inflight) < 8'(FIFO_DEPTH);

    assign hist_rw   = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign bin_addr  = bin_addr_q;
    assign bin_rd    = bin_rd_q;
    assign start_err = start_err_q;

    // Count reads strobed but not yet returned (strobe plus latency pipe).
    always_comb begin
        inflight = 8'(bin_rd_q);
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + 8'(vld_sr_q[i]);
        end
    end

    // Next-state, FIFO push and read-issue decisions.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_word = '0;
        issue     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_word = {1'b0, hdr_word(frame_q)};
                    state_d   = ST_RD;
                end
            end
            ST_RD: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (last_bin) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (inflight == '0) begin
                    state_d = ST_FTR;
                end
            end
            ST_FTR: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_word = {1'b1, sum_q};
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (footer_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Returned bin data only arrives in RD/WAIT, never alongside header/footer.
        if (data_valid) begin
            push      = 1'b1;
            push_word = {1'b0, 8'h00, bin_data};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame capture, address walk, read-latency pipe, checksum and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q     <= '0;
            sum_q       <= '0;
            rd_idx_q    <= '0;
            bin_addr_q  <= '0;
            bin_rd_q    <= 1'b0;
            vld_sr_q    <= '0;
            start_err_q <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && start) begin
                frame_q  <= frame_id;
                sum_q    <= '0;
                rd_idx_q <= '0;
            end
            if (issue) begin
                bin_addr_q <= rd_idx_q;
                rd_idx_q   <= rd_idx_q + BIN_W'(1);
            end
            bin_rd_q    <= issue;
            vld_sr_q[0] <= bin_rd_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr_q[i] <= vld_sr_q[i-1];
            end
            if (data_valid) begin
                sum_q <= sum_q + OUT_W'(bin_data);
            end
            start_err_q <= start && (state_q != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_histo_readout.sv
// Bench for histo_readout: clear-on-read histogram RAM model, expected-packet
// queue built from a RAM snapshot at start, and a per-cycle stream checker.
module tb_histo_readout;
    import histo_readout_pkg::*;

    logic             clk;
    logic             rst;
    logic             start;
    logic [15:0]      frame_id;
    logic             hist_rw;
    logic [BIN_W-1:0] bin_addr;
    logic             bin_rd;
    logic [CNT_W-1:0] bin_data;
    logic             busy;
    logic             start_err;

    histo_readout_if s_if ();

    histo_readout dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame_id  (frame_id),
        .hist_rw   (hist_rw),
        .bin_addr  (bin_addr),
        .bin_rd    (bin_rd),
        .bin_data  (bin_data),
        .out_if    (s_if),
        .busy      (busy),
        .start_err (start_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [CNT_W-1:0] ram [NUM_BINS];
    logic [32:0]      exp_q [$];
    logic [31:0]      model_footer;
    int               word_cnt = 0;
    int               rd_cnt   = 0;
    int               dup_cnt  = 0;
    int               max_out  = 0;
    bit               rd_seen [NUM_BINS];
    logic [31:0]      first_word;
    logic [31:0]      second_word;
    logic [31:0]      last_word;
    int               ready_mode = 0;
    logic             ready_val  = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Histogram RAM: data RD_LAT(=1) clock after the strobe, bin cleared by the read.
    always @(posedge clk) begin
        if (bin_rd) begin
            bin_data <= ram[bin_addr];
            ram[bin_addr] = '0;
        end
    end

    // Sink ready: fixed level or random ~30% high.
    initial begin
        s_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            s_if.out_ready = (ready_mode != 0) ? ($urandom_range(0, 99) < 30) : ready_val;
        end
    end

    // Stream checker, read tracker and buffering bound, sampled mid-cycle.
    initial begin : monitor
        logic        stall_prev;
        logic [31:0] stall_data;
        logic        stall_last;
        logic [32:0] e;
        int          outstanding;
        stall_prev = 1'b0;
        stall_data = '0;
        stall_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_valid", 64'(s_if.out_valid), 64'd1);
                    chk("stall_data", 64'(s_if.out_data), 64'(stall_data));
                    chk("stall_last", 64'(s_if.out_last), 64'(stall_last));
                end
                if (s_if.out_valid && s_if.out_ready) begin
                    chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("out_data", 64'(s_if.out_data), 64'(e[31:0]));
                        chk("out_last", 64'(s_if.out_last), 64'(e[32]));
                    end
                    word_cnt++;
                    if (word_cnt == 1) first_word = s_if.out_data;
                    if (word_cnt == 2) second_word = s_if.out_data;
                    last_word = s_if.out_data;
                end
                stall_prev = s_if.out_valid && !s_if.out_ready;
                stall_data = s_if.out_data;
                stall_last = s_if.out_last;
                if (bin_rd) begin
                    rd_cnt++;
                    if (rd_seen[bin_addr]) dup_cnt++;
                    rd_seen[bin_addr] = 1'b1;
                end
                outstanding = rd_cnt - ((word_cnt > 0) ? word_cnt - 1 : 0);
                if (outstanding > max_out) max_out = outstanding;
            end
        end
    end

    // Expected packet from the RAM contents at start time.
    task automatic build_expected(input logic [15:0] fid);
        logic [31:0] s;
        s = '0;
        exp_q.delete();
        exp_q.push_back({1'b0, 8'hA5, 8'h48, fid});
        for (int i = 0; i < NUM_BINS; i++) begin
            exp_q.push_back({1'b0, 8'h00, ram[i]});
            s = s + {8'h00, ram[i]};
        end
        exp_q.push_back({1'b1, s});
        model_footer = s;
    endtask

    task automatic launch(input logic [15:0] fid);
        build_expected(fid);
        chk("model_len", 64'(exp_q.size()), 64'(PKT_WORDS));
        word_cnt = 0;
        rd_cnt   = 0;
        dup_cnt  = 0;
        max_out  = 0;
        for (int i = 0; i < NUM_BINS; i++) rd_seen[i] = 1'b0;
        frame_id = fid;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while ((busy || exp_q.size() != 0) && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("done_in_budget", 64'(cycles < budget), 64'd1);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("rd_count", 64'(rd_cnt), 64'(NUM_BINS));
        chk("rd_dups", 64'(dup_cnt), 64'd0);
        chk("buffered_le_depth", 64'(max_out <= FIFO_DEPTH), 64'd1);
        chk("hist_rw_back", 64'(hist_rw), 64'd1);
        chk("busy_clear", 64'(busy), 64'd0);
    endtask

    task automatic wait_rd(input int n, input int budget);
        int c;
        c = 0;
        while (rd_cnt < n && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("wait_rd_budget", 64'(c < budget), 64'd1);
    endtask

    task automatic wait_words(input int n, input int budget);
        int c;
        c = 0;
        while (word_cnt < n && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("wait_words_budget", 64'(c < budget), 64'd1);
    endtask

    task automatic wait_footer(input int budget);
        int c;
        c = 0;
        while (!(s_if.out_valid && s_if.out_last) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("wait_footer_budget", 64'(c < budget), 64'd1);
    endtask

    initial begin
        int cyc;
        rst      = 1'b1;
        start    = 1'b0;
        frame_id = '0;
        for (int i = 0; i < NUM_BINS; i++) ram[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hist_rw", 64'(hist_rw), 64'd1);
        chk("rst_bin_addr", 64'(bin_addr), 64'd0);
        chk("rst_bin_rd", 64'(bin_rd), 64'd0);
        chk("rst_out_valid", 64'(s_if.out_valid), 64'd0);
        chk("rst_out_last", 64'(s_if.out_last), 64'd0);
        chk("rst_out_data", 64'(s_if.out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_start_err", 64'(start_err), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Index preload, ready high: header latency and full-rate packet.
        for (int i = 0; i < NUM_BINS; i++) ram[i] = CNT_W'(i);
        launch(16'h1234);
        chk("lat_busy", 64'(busy), 64'd1);
        chk("lat_hist_rw", 64'(hist_rw), 64'd0);
        chk("lat_not_yet_valid", 64'(s_if.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_hdr_valid", 64'(s_if.out_valid), 64'd1);
        chk("lat_hdr_word", 64'(s_if.out_data), 64'h0000_0000_A548_1234);
        wait_done(NUM_BINS + 8, cyc);
        chk("t1_first_word", 64'(first_word), 64'h0000_0000_A548_1234);
        chk("t1_footer", 64'(last_word), 64'd523776);
        chk("t1_model_footer", 64'(model_footer), 64'd523776);

        // Same preload, random ready.
        for (int i = 0; i < NUM_BINS; i++) ram[i] = CNT_W'(i);
        ready_mode = 1;
        launch(16'h1234);
        wait_done(20000, cyc);
        ready_mode = 0;
        @(posedge clk);
        #1;
        chk("t2_first_word", 64'(first_word), 64'h0000_0000_A548_1234);
        chk("t2_footer", 64'(last_word), 64'd523776);

        // Saturated bins: checksum wraps; start coincident with footer handshake.
        for (int i = 0; i < NUM_BINS; i++) ram[i] = 24'hFFFFFF;
        launch(16'hBEEF);
        wait_footer(3000);
        frame_id = 16'h7777;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ftr_start_err", 64'(start_err), 64'd1);
        chk("ftr_start_ignored", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("ftr_start_err_pulse", 64'(start_err), 64'd0);
        chk("ftr_still_idle", 64'(busy), 64'd0);
        wait_done(10, cyc);
        chk("t3_data_word", 64'(second_word), 64'h0000_0000_00FF_FFFF);
        chk("t3_footer", 64'(last_word), 64'h0000_0000_FFFF_FC00);
        chk("t3_model_footer", 64'(model_footer), 64'h0000_0000_FFFF_FC00);

        // start while busy at bin 500.
        for (int i = 0; i < NUM_BINS; i++) ram[i] = CNT_W'(i) ^ 24'h5A5A5A;
        launch(16'h0A04);
        wait_rd(500, 2000);
        frame_id = 16'hFFFF;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("mid_start_err", 64'(start_err), 64'd1);
        chk("mid_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        chk("mid_start_err_pulse", 64'(start_err), 64'd0);
        wait_done(2000, cyc);
        chk("t4_first_word", 64'(first_word), 64'h0000_0000_A548_0A04);

        // Reset at word 300, then a fresh packet from the partly cleared RAM.
        for (int i = 0; i < NUM_BINS; i++) ram[i] = CNT_W'(i * 3 + 1);
        launch(16'h0505);
        wait_words(300, 2000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_out_valid", 64'(s_if.out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hist_rw", 64'(hist_rw), 64'd1);
        chk("abort_bin_rd", 64'(bin_rd), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        launch(16'h0506);
        wait_done(2000, cyc);
        chk("t5_first_word", 64'(first_word), 64'h0000_0000_A548_0506);

        // Sink stalled 100 cycles: header held, reads stop at FIFO credit.
        ready_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NUM_BINS; i++) ram[i] = CNT_W'(NUM_BINS - 1 - i);
        launch(16'h0606);
        repeat (100) @(posedge clk);
        #1;
        chk("stall_hdr_valid", 64'(s_if.out_valid), 64'd1);
        chk("stall_hdr_word", 64'(s_if.out_data), 64'h0000_0000_A548_0606);
        chk("stall_rd_credit", 64'(rd_cnt), 64'(FIFO_DEPTH - 1));
        chk("stall_bin_rd_low", 64'(bin_rd), 64'd0);
        ready_val = 1'b1;
        wait_done(NUM_BINS + 50, cyc);
        chk("t6_footer", 64'(last_word), 64'd523776);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
